// File: rtl/usb_stream_in_source.sv
// rtl/usb_stream_in_source.sv - FWFT upstream buffer with burst request for the FX3 stream-in writer
//
// Optional feature macro: USB_STREAM_IN_SRC_COUNTER_EN
//   When defined, test_mode=1 replaces the push word with an internal 32-bit counter
//   and treats src_valid as 1. When undefined, test_mode is ignored.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   src_data/src_valid    upstream word and valid; src_ready = !full
//   test_mode             counter pattern select (macro builds only)
//   pop                   writer consumed data_out on this edge
//   data_out              head word (asynchronous read), 0 when empty
//   empty/full/level      FIFO status, level = stored word count
//   stream_req            burst in progress (PKT_WORDS words owed to the writer)
//   overflow/underflow    sticky error flags, cleared only by reset
module usb_stream_in_source #(
    parameter int DEPTH_LOG2 = 9,
    parameter int PKT_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic                  test_mode,
    input  logic                  pop,
    output logic [31:0]           data_out,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  stream_req,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PKT_LVL  = (DEPTH_LOG2 + 1)'(PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01
    } state_t;

    logic [31:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] burst_cnt_q, burst_cnt_d;
    state_t              state_q, state_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                push_valid;
    logic [31:0]         push_data;
    logic                push;
    logic                pop_ok;

`ifdef USB_STREAM_IN_SRC_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;

    assign push_valid = test_mode ? 1'b1 : src_valid;
    assign push_data  = test_mode ? cnt_q : src_data;

    always_comb begin
        cnt_d = cnt_q;
        if (push) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign push_valid       = src_valid;
    assign push_data        = src_data;
`endif

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level      = wr_ptr_q - rd_ptr_q;
    assign empty      = (level == '0);
    assign full       = (level == FULL_LVL);
    assign src_ready  = !full;
    assign push       = push_valid && !full;
    assign pop_ok     = pop && !empty;
    assign data_out   = empty ? 32'd0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_valid && full) begin
            overflow_d = 1'b1;
        end
        if (pop && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Burst controller: one packet is owed once enough words are buffered;
    // pops made while IDLE are honoured but not counted against a burst.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        stream_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (level >= PKT_LVL) begin
                    state_d     = BURST;
                    burst_cnt_d = PKT_LVL;
                end
            end
            BURST: begin
                stream_req = 1'b1;
                if (pop_ok) begin
                    burst_cnt_d = burst_cnt_q - 1'b1;
                    if (burst_cnt_q == (DEPTH_LOG2 + 1)'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            burst_cnt_q <= '0;
            state_q     <= IDLE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_usb_stream_in_source.sv
// tb/tb_usb_stream_in_source.sv - directed self-checking bench for usb_stream_in_source
module tb_usb_stream_in_source;

    logic        clk;
    logic        rst_n;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        test_mode;
    logic        pop;
    logic [31:0] data_out;
    logic        empty;
    logic        full;
    logic [9:0]  level;
    logic        stream_req;
    logic        overflow;
    logic        underflow;

    int checks;
    int errors;

    usb_stream_in_source #(
        .DEPTH_LOG2 (9),
        .PKT_WORDS  (256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .test_mode  (test_mode),
        .pop        (pop),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .stream_req (stream_req),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic m_st;
        int   m_cnt;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        src_data  = 32'd0;
        src_valid = 1'b0;
        test_mode = 1'b0;
        pop       = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd1);
        check("rst_data_out", data_out, 32'd0);
        check("rst_stream_req", 32'(stream_req), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);

        // One packet of 256 words, no pops.
        src_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            src_data = 32'hA000_0000 + 32'(i);
            step();
            if (i == 0) begin
                check("first_push_empty", 32'(empty), 32'd0);
                check("first_push_data", data_out, 32'hA000_0000);
            end
        end
        src_valid = 1'b0;
        check("pkt_level", 32'(level), 32'd256);
        check("pkt_req_not_yet", 32'(stream_req), 32'd0);
        check("pkt_head", data_out, 32'hA000_0000);
        step();
        check("pkt_req_rise", 32'(stream_req), 32'd1);

        // Drain the packet; request must fall on the 256th pop edge.
        pop = 1'b1;
        for (int i = 0; i < 256; i++) begin
            check("drain_data", data_out, 32'hA000_0000 + 32'(i));
            step();
            if (i == 254) begin
                check("drain_req_held", 32'(stream_req), 32'd1);
            end
        end
        pop = 1'b0;
        check("drain_req_fall", 32'(stream_req), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_data_zero", data_out, 32'd0);
        check("drain_level", 32'(level), 32'd0);

        // Pop while empty.
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_level", 32'(level), 32'd0);
        check("uf_overflow_clear", 32'(overflow), 32'd0);

        // Fill to 512 then push once more.
        src_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            src_data = 32'hB000_0000 + 32'(i);
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_src_ready", 32'(src_ready), 32'd0);
        check("fill_level", 32'(level), 32'd512);
        check("fill_no_overflow_yet", 32'(overflow), 32'd0);
        src_data = 32'hDEAD_BEEF;
        step();
        check("of_flag", 32'(overflow), 32'd1);
        check("of_level", 32'(level), 32'd512);
        check("of_head", data_out, 32'hB000_0000);

        // Pop while full with src_valid high: push is blocked on that edge.
        pop = 1'b1;
        step();
        pop       = 1'b0;
        src_valid = 1'b0;
        check("fullpop_level", 32'(level), 32'd511);
        check("fullpop_src_ready", 32'(src_ready), 32'd1);
        check("fullpop_head", data_out, 32'hB000_0001);
        check("fullpop_req", 32'(stream_req), 32'd1);

        // Reset in the middle of a burst.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_req", 32'(stream_req), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_underflow", 32'(underflow), 32'd0);

        // Steady state at level 300 with push and pop every cycle.
        src_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            src_data = 32'hC000_0000 + 32'(i);
            step();
        end
        check("steady_start_level", 32'(level), 32'd300);
        m_st  = 1'b1;
        m_cnt = 256;
        pop   = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            src_data = 32'hC000_0000 + 32'(300 + k);
            check("steady_data", data_out, 32'hC000_0000 + 32'(k));
            check("steady_level", 32'(level), 32'd300);
            check("steady_req", 32'(stream_req), 32'(m_st));
            if (!m_st) begin
                m_st  = 1'b1;
                m_cnt = 256;
            end else begin
                if (m_cnt == 1) begin
                    m_st = 1'b0;
                end
                m_cnt--;
            end
            step();
        end
        pop       = 1'b0;
        src_valid = 1'b0;
        check("steady_end_level", 32'(level), 32'd300);
        check("steady_end_head", data_out, 32'hC000_0000 + 32'd1000);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

`ifdef USB_STREAM_IN_SRC_COUNTER_EN
        test_mode = 1'b1;
        step();
        check("cnt_first", data_out, 32'd0);
        pop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("cnt_seq", data_out, 32'(k));
            step();
        end
        pop       = 1'b0;
        test_mode = 1'b0;
        check("cnt_level", 32'(level), 32'd1);
`else
        test_mode = 1'b1;
        step();
        step();
        test_mode = 1'b0;
        check("tm_ignored_level", 32'(level), 32'd0);
        check("tm_ignored_empty", 32'(empty), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
